// File: rtl/fetch_pkg.sv
// Shared widths, FSM state encoding and constants for the fetch memory responder.
package fetch_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    localparam logic [DATA_W-1:0] NOP_INSTR = 16'h0000;

endpackage

// File: rtl/fetch_mem_resp_if.sv
// Fetch request/response channel plus the preload write port.
interface fetch_mem_resp_if
    import fetch_pkg::*;
();

    logic              req_valid;
    logic [ADDR_W-1:0] req_addr;
    logic              req_ready;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_data;
    logic              resp_err;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    modport master (
        output req_valid, req_addr, wr_en, wr_addr, wr_data,
        input  req_ready, resp_valid, resp_data, resp_err
    );

    modport slave (
        input  req_valid, req_addr, wr_en, wr_addr, wr_data,
        output req_ready, resp_valid, resp_data, resp_err
    );

endinterface

// File: rtl/fetch_mem_array.sv
// Word store addressed by byte address: one write port, one registered read port.
module fetch_mem_array
    import fetch_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [DATA_W-1:0]     mem [DEPTH];
    logic [DATA_W-1:0]     rd_data_reg;
    logic [DEPTH_LOG2-1:0] rd_idx;
    logic [DEPTH_LOG2-1:0] wr_idx;
    logic                  addr_unused;

    // Bit 0 and bits above the word index are dropped, so addresses alias.
    assign rd_idx      = rd_addr[DEPTH_LOG2:1];
    assign wr_idx      = wr_addr[DEPTH_LOG2:1];
    assign addr_unused = ^{rd_addr, wr_addr};

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_reg <= '0;
        end else if (rd_en) begin
            rd_data_reg <= mem[rd_idx];
        end
    end

    assign rd_data = rd_data_reg;

endmodule

// File: rtl/fetch_mem_resp.sv
// Instruction-memory responder: fixed-latency reads, misalignment flag, preload port.
// Define FETCH_MEM_NEXTLINE_EN to add a one-entry next-line buffer with 1-cycle hits.
module fetch_mem_resp
    import fetch_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 2
) (
    input  logic            clk,
    input  logic            rst,
    fetch_mem_resp_if.slave bus
);
    localparam int CNT_W = $clog2(LATENCY + 1);

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic              err_reg;
    logic              resp_err_reg;
    logic [DATA_W-1:0] resp_data_reg;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] cap_data;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_en;
    logic              accept;
    logic              aligned;
    logic              fast;

    assign bus.req_ready = (state_reg != ST_BUSY);
    assign accept        = bus.req_valid && bus.req_ready;
    assign aligned       = ~bus.req_addr[0];

`ifdef FETCH_MEM_NEXTLINE_EN
    typedef logic [DEPTH_LOG2-1:0] word_t;

    word_t             req_word, wr_word, nl_next_tag, nl_tag_reg;
    logic [DATA_W-1:0] nl_data_reg, hold_data_reg, hit_data;
    logic              nl_valid_reg, nl_pend_reg, pf_req_reg, src_hold_reg;
    logic              nl_hit, miss_rd, pf_issue;

    assign req_word    = bus.req_addr[DEPTH_LOG2:1];
    assign wr_word     = bus.wr_addr[DEPTH_LOG2:1];
    assign nl_next_tag = (accept && aligned) ? req_word + word_t'(1) : nl_tag_reg;
    // A prefetch read still landing in rd_data is good enough to serve a hit.
    assign nl_hit      = accept && aligned && (nl_valid_reg || nl_pend_reg)
                         && (nl_tag_reg == req_word);
    assign hit_data    = nl_pend_reg ? rd_data : nl_data_reg;
    assign miss_rd     = accept && aligned && !nl_hit;
    assign pf_issue    = nl_hit || pf_req_reg;
    assign rd_en       = miss_rd || pf_issue;
    assign rd_addr     = miss_rd ? bus.req_addr : ADDR_W'({nl_next_tag, 1'b0});
    assign fast        = (LATENCY == 1) || nl_hit;
    assign cap_data    = err_reg ? NOP_INSTR : (src_hold_reg ? hold_data_reg : rd_data);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nl_tag_reg    <= '0;
            nl_data_reg   <= '0;
            hold_data_reg <= '0;
            nl_valid_reg  <= 1'b0;
            nl_pend_reg   <= 1'b0;
            pf_req_reg    <= 1'b0;
            src_hold_reg  <= 1'b0;
        end else begin
            pf_req_reg  <= 1'b0;
            nl_pend_reg <= pf_issue;
            if (nl_pend_reg) begin
                nl_data_reg  <= rd_data;
                nl_valid_reg <= 1'b1;
            end
            // On a miss the next-line read reuses the port, so park the fetched word first.
            if (pf_req_reg) begin
                hold_data_reg <= rd_data;
                src_hold_reg  <= 1'b1;
            end
            if (accept) begin
                nl_valid_reg <= 1'b0;
                src_hold_reg <= nl_hit;
                if (nl_hit) begin
                    hold_data_reg <= hit_data;
                end
                if (aligned) begin
                    nl_tag_reg <= nl_next_tag;
                    pf_req_reg <= !nl_hit && (LATENCY > 1);
                end
            end
            if (bus.wr_en && (wr_word == nl_next_tag)) begin
                nl_valid_reg <= 1'b0;
                nl_pend_reg  <= 1'b0;
                pf_req_reg   <= 1'b0;
            end
        end
    end
`else
    assign rd_en    = accept && aligned;
    assign rd_addr  = bus.req_addr;
    assign fast     = (LATENCY == 1);
    assign cap_data = err_reg ? NOP_INSTR : rd_data;
`endif

    fetch_mem_array #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_mem (
        .clk    (clk),
        .rst    (rst),
        .rd_en  (rd_en),
        .rd_addr(rd_addr),
        .rd_data(rd_data),
        .wr_en  (bus.wr_en),
        .wr_addr(bus.wr_addr),
        .wr_data(bus.wr_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            err_reg       <= 1'b0;
            resp_data_reg <= '0;
            resp_err_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (accept) begin
                err_reg <= ~aligned;
            end
            if (state_reg == ST_RESP) begin
                resp_data_reg <= cap_data;
                resp_err_reg  <= err_reg;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            ST_IDLE, ST_RESP: begin
                if (accept) begin
                    cnt_next   = CNT_W'(LATENCY - 1);
                    state_next = fast ? ST_RESP : ST_BUSY;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_BUSY: begin
                cnt_next = cnt_reg - CNT_W'(1);
                if (cnt_reg == CNT_W'(1)) begin
                    state_next = ST_RESP;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Between pulses the outputs hold whatever the last response carried.
    assign bus.resp_valid = (state_reg == ST_RESP);
    assign bus.resp_data  = bus.resp_valid ? cap_data : resp_data_reg;
    assign bus.resp_err   = bus.resp_valid ? err_reg : resp_err_reg;

endmodule

// File: tb/tb_fetch_mem_resp.sv
// Scoreboard bench for fetch_mem_resp: directed scenarios followed by random traffic.
module tb_fetch_mem_resp;
    import fetch_pkg::*;

    localparam int LAT    = 2;
    localparam int DL2    = 10;
    localparam int NWORDS = 1 << DL2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    fetch_mem_resp_if bus ();

    fetch_mem_resp #(
        .DEPTH_LOG2(DL2),
        .LATENCY   (LAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] data;
        logic        err;
        int          due;
        int          addr;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] ref_mem [NWORDS];
    int          nl_tag = 0;
    bit          nl_valid = 1'b0;
    logic [15:0] last_data = 16'h0;
    logic        last_err = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference model: word index from byte address, old data on a same-cycle write.
    task automatic model_accept(input int addr);
        exp_t e;
        int   w;
        int   lat;
        w      = (addr % (2 * NWORDS)) / 2;
        lat    = LAT;
        e.addr = addr;
        if (addr % 2 == 1) begin
            e.data   = 16'h0000;
            e.err    = 1'b1;
            nl_valid = 1'b0;
        end else begin
            e.data = ref_mem[w];
            e.err  = 1'b0;
`ifdef FETCH_MEM_NEXTLINE_EN
            if (nl_valid && nl_tag == w) lat = 1;
            nl_tag   = (w + 1) % NWORDS;
            nl_valid = 1'b1;
`endif
        end
        e.due = cyc + lat;
        exp_q.push_back(e);
    endtask

    task automatic model_write(input int addr, input logic [15:0] d);
        int w;
        w          = (addr % (2 * NWORDS)) / 2;
        ref_mem[w] = d;
        if (nl_tag == w) nl_valid = 1'b0;
    endtask

    task automatic step(input bit v, input int addr, input bit we, input int waddr,
                        input logic [15:0] wd);
        @(negedge clk);
        bus.req_valid = v;
        bus.req_addr  = 16'(addr);
        bus.wr_en     = we;
        bus.wr_addr   = 16'(waddr);
        bus.wr_data   = wd;
        if (v && bus.req_ready === 1'b1) model_accept(addr);
        if (we) model_write(waddr, wd);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0, 0, 16'h0);
    endtask

    initial begin : monitor
        exp_t e;
        bit   due_now;
        bit   busy;
        forever begin
            @(posedge clk);
            #2;
            if (rst) begin
                last_data = 16'h0;
                last_err  = 1'b0;
            end else begin
                due_now = (exp_q.size() > 0) && (exp_q[0].due == cyc);
                busy    = (exp_q.size() > 0) && (exp_q[0].due > cyc);
                check("req_ready", bus.req_ready, !busy);
                check("resp_valid", bus.resp_valid, due_now);
                if (due_now) begin
                    e = exp_q.pop_front();
                    check("resp_data", bus.resp_data, e.data);
                    check("resp_err", bus.resp_err, e.err);
                    $display("resp addr=%04h data=%04h err=%0d cycle=%0d",
                             e.addr, bus.resp_data, bus.resp_err, cyc);
                    last_data = e.data;
                    last_err  = e.err;
                end else begin
                    check("hold_data", bus.resp_data, last_data);
                    check("hold_err", bus.resp_err, last_err);
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        int last_a;
        int a;
        int wa;
        bit v;
        bit we;
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.wr_en     = 1'b0;
        bus.wr_addr   = '0;
        bus.wr_data   = '0;
        repeat (3) @(negedge clk);
        check("rst_req_ready", bus.req_ready, 1);
        check("rst_resp_valid", bus.resp_valid, 0);
        check("rst_resp_data", bus.resp_data, 0);
        check("rst_resp_err", bus.resp_err, 0);
        rst = 1'b0;

        for (int i = 0; i < NWORDS; i++) step(1'b0, 0, 1'b1, 2 * i, 16'($urandom));

        // Reset in the middle of an access drops it
        step(1'b1, 16'h0040, 1'b0, 0, 16'h0);
        @(negedge clk);
        bus.req_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("midrst_req_ready", bus.req_ready, 1);
        check("midrst_resp_valid", bus.resp_valid, 0);
        exp_q.delete();
        nl_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle(5);

        // Basic read
        step(1'b0, 0, 1'b1, 16'h0000, 16'hA5C3);
        step(1'b1, 16'h0000, 1'b0, 0, 16'h0);
        idle(4);

        // Back-to-back, second request held until the response cycle
        step(1'b0, 0, 1'b1, 16'h0002, 16'h1111);
        step(1'b0, 0, 1'b1, 16'h0004, 16'h2222);
        step(1'b1, 16'h0002, 1'b0, 0, 16'h0);
        step(1'b1, 16'h0004, 1'b0, 0, 16'h0);
        step(1'b1, 16'h0004, 1'b0, 0, 16'h0);
        idle(4);

        // Misaligned
        step(1'b1, 16'h0003, 1'b0, 0, 16'h0);
        idle(4);

        // Aliased write racing the read
        step(1'b0, 0, 1'b1, 16'h0000, 16'h1234);
        step(1'b1, 16'h0000, 1'b1, 16'h0800, 16'hBEEF);
        idle(3);
        step(1'b1, 16'h0000, 1'b0, 0, 16'h0);
        idle(4);

        // Sequential pair, then the same pair with the second word rewritten between
        step(1'b1, 16'h0010, 1'b0, 0, 16'h0);
        idle(3);
        step(1'b1, 16'h0012, 1'b0, 0, 16'h0);
        idle(3);
        step(1'b1, 16'h0010, 1'b0, 0, 16'h0);
        idle(3);
        step(1'b0, 0, 1'b1, 16'h0012, 16'h5A5A);
        step(1'b1, 16'h0012, 1'b0, 0, 16'h0);
        idle(4);

        // Random traffic, biased toward sequential fetch so the buffer is exercised
        last_a = 16'h0100;
        for (int i = 0; i < 400; i++) begin
            v = ($urandom_range(0, 9) < 7);
            case ($urandom_range(0, 4))
                0, 1:    a = (last_a + 2) & 16'hFFFF;
                2:       a = last_a;
                3:       a = $urandom_range(0, 65535);
                default: a = (last_a + 1) & 16'hFFFF;
            endcase
            we = ($urandom_range(0, 4) == 0);
            wa = ($urandom_range(0, 1) == 0) ? ((last_a + 2) & 16'hFFFF)
                                             : $urandom_range(0, 65535);
            step(v, a, we, wa, 16'($urandom));
            if (v) last_a = a;
        end
        idle(LAT + 4);
        check("queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
